// File: rtl/up_spi_pkg.sv
// Shared definitions for the SPI register sequencer: register word addresses,
// CR bit positions, FSM state encoding and the CR "go" word builder.
package up_spi_pkg;

  // Word addresses of the SPI peripheral registers.
  localparam int ADDR_CR  = 0;
  localparam int ADDR_SR  = 1;
  localparam int ADDR_ODR = 2;
  localparam int ADDR_PSC = 3;

  // CR bit positions.
  localparam int CR_EN_BIT     = 0;
  localparam int CR_CPOL_BIT   = 1;
  localparam int CR_CPHA_BIT   = 2;
  localparam int CR_ENTX_BIT   = 3;
  localparam int CR_DATSIZ_LSB = 8;
  localparam int CR_CS_LSB     = 16;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DIS,
    LOAD,
    GO,
    POLL,
    PWAIT
  } state_t;

  // CR value that starts a transfer; cs arrives zero-extended to 16 bits.
  function automatic logic [31:0] cr_go_word(input logic [15:0] cs,
                                             input logic [5:0]  len,
                                             input logic        cpol,
                                             input logic        cpha);
    logic [31:0] w;
    w                          = '0;
    w[CR_EN_BIT]               = 1'b1;
    w[CR_CPOL_BIT]             = cpol;
    w[CR_CPHA_BIT]             = cpha;
    w[CR_ENTX_BIT]             = 1'b1;
    w[CR_DATSIZ_LSB +: 6]      = len;
    w[CR_CS_LSB +: 16]         = cs;
    return w;
  endfunction

endpackage

// File: rtl/up_spi_seq_fifo.sv
// Command FIFO: power-of-two depth, pointers with a wrap bit, head visible
// combinationally so the sequencer can capture it on the pop cycle.
module up_spi_seq_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             up_clk,
  input  logic             up_rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_pop;
  logic             do_push;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop    = pop & ~empty;
  // A simultaneous pop frees the slot, so a push while full is still taken.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage array; no reset so it maps onto RAM primitives.
  always_ff @(posedge up_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers; reset empties the FIFO.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/up_spi_seq.sv
// SPI register sequencer: programs the prescaler once, then for each queued
// command disables the core, loads ODR, starts the transfer and polls SR.
module up_spi_seq
  import up_spi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int CS_CNT        = 2,
  parameter int PSC_VAL       = 4,
  parameter int CPOL          = 0,
  parameter int CPHA          = 0,
  parameter int FIFO_DEPTH    = 4,
  parameter int POLL_MAX      = 1023
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CS_CNT-1:0]        cmd_cs,
  input  logic [5:0]               cmd_len,
  input  logic [31:0]              cmd_data,
  output logic                     m_up_wreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_waddr,
  output logic [31:0]              m_up_wdata,
  input  logic                     m_up_wack,
  output logic                     m_up_rreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_raddr,
  input  logic [31:0]              m_up_rdata,
  input  logic                     m_up_rack,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int FW    = 6 + CS_CNT + 32;

  state_t                   state_reg, state_next;
  logic                     pend_reg, pend_next;
  logic                     wreq_reg, wreq_next;
  logic [ADDRESS_WIDTH-1:0] waddr_reg, waddr_next;
  logic [31:0]              wdata_reg, wdata_next;
  logic                     rreq_reg, rreq_next;
  logic [ADDRESS_WIDTH-1:0] raddr_reg, raddr_next;
  logic                     done_reg, done_next;
  logic                     err_reg, err_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [FW-1:0]            hold_reg, hold_next;
  logic                     rdy_reg;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FW-1:0]            fifo_head;

  logic                     wr_active;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [31:0]              wr_data;
  state_t                   wr_dst;

  logic [CS_CNT-1:0]        hold_cs;
  logic [5:0]               hold_len;
  logic [31:0]              hold_data;
  logic                     sr_unused;

  assign hold_cs   = hold_reg[FW-1 -: CS_CNT];
  assign hold_len  = hold_reg[37:32];
  assign hold_data = hold_reg[31:0];
  // Only SR bit 0 (busy) matters to the sequencer.
  assign sr_unused = ^m_up_rdata[31:1];

  assign cmd_ready  = rdy_reg & ~fifo_full;
  assign fifo_push  = cmd_valid & cmd_ready;
  assign busy       = ((state_reg != INIT) && (state_reg != IDLE)) | ~fifo_empty;
  assign m_up_wreq  = wreq_reg;
  assign m_up_waddr = waddr_reg;
  assign m_up_wdata = wdata_reg;
  assign m_up_rreq  = rreq_reg;
  assign m_up_raddr = raddr_reg;
  assign done       = done_reg;
  assign err        = err_reg;

  up_spi_seq_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .up_clk    (up_clk),
    .up_rstn   (up_rstn),
    .push      (fifo_push),
    .push_data ({cmd_cs, cmd_len, cmd_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and bus-request decode; write states share one handshake path.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    wreq_next  = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    rreq_next  = 1'b0;
    raddr_next = raddr_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    fifo_pop   = 1'b0;
    wr_active  = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_dst     = state_reg;

    case (state_reg)
      INIT: begin
        wr_active = 1'b1;
        wr_addr   = ADDRESS_WIDTH'(ADDR_PSC);
        wr_data   = 32'(PSC_VAL);
        wr_dst    = IDLE;
      end
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          hold_next  = fifo_head;
          state_next = DIS;
        end
      end
      DIS: begin
        wr_active = 1'b1;
        wr_addr   = ADDRESS_WIDTH'(ADDR_CR);
        wr_data   = 32'h0;
        wr_dst    = LOAD;
      end
      LOAD: begin
        wr_active = 1'b1;
        wr_addr   = ADDRESS_WIDTH'(ADDR_ODR);
        wr_data   = hold_data;
        wr_dst    = GO;
      end
      GO: begin
        wr_active = 1'b1;
        wr_addr   = ADDRESS_WIDTH'(ADDR_CR);
        wr_data   = cr_go_word(16'(hold_cs), hold_len, 1'(CPOL), 1'(CPHA));
        wr_dst    = POLL;
      end
      POLL: begin
        rreq_next  = 1'b1;
        raddr_next = ADDRESS_WIDTH'(ADDR_SR);
        state_next = PWAIT;
      end
      PWAIT: begin
        if (m_up_rack) begin
          if (!m_up_rdata[0]) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else if (cnt_reg == CNT_W'(POLL_MAX)) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
            state_next = POLL;
          end
        end
      end
      default: state_next = INIT;
    endcase

    // Issue once per state, then wait for the ack; the poll counter is
    // cleared on every write completion so POLL always starts from zero.
    if (wr_active) begin
      if (!pend_reg) begin
        wreq_next  = 1'b1;
        waddr_next = wr_addr;
        wdata_next = wr_data;
        pend_next  = 1'b1;
      end else if (m_up_wack) begin
        pend_next  = 1'b0;
        cnt_next   = '0;
        state_next = wr_dst;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      state_reg <= INIT;
      pend_reg  <= 1'b0;
      wreq_reg  <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      rreq_reg  <= 1'b0;
      raddr_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      hold_reg  <= '0;
      rdy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      wreq_reg  <= wreq_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      rreq_reg  <= rreq_next;
      raddr_reg <= raddr_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
      rdy_reg   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_up_spi_seq.sv
// Directed bench for up_spi_seq: behavioural register-bus slave with
// programmable ack delay / stall and scripted SR responses.
module tb_up_spi_seq;

  localparam int AW = 12;

  logic          up_clk;
  logic          up_rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_cs;
  logic [5:0]    cmd_len;
  logic [31:0]   cmd_data;
  logic          m_up_wreq;
  logic [AW-1:0] m_up_waddr;
  logic [31:0]   m_up_wdata;
  logic          m_up_wack;
  logic          m_up_rreq;
  logic [AW-1:0] m_up_raddr;
  logic [31:0]   m_up_rdata;
  logic          m_up_rack;
  logic          busy;
  logic          done;
  logic          err;

  up_spi_seq #(
    .ADDRESS_WIDTH (AW),
    .CS_CNT        (2),
    .PSC_VAL       (4),
    .CPOL          (0),
    .CPHA          (1),
    .FIFO_DEPTH    (4),
    .POLL_MAX      (3)
  ) dut (
    .up_clk     (up_clk),
    .up_rstn    (up_rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_cs     (cmd_cs),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .m_up_wreq  (m_up_wreq),
    .m_up_waddr (m_up_waddr),
    .m_up_wdata (m_up_wdata),
    .m_up_wack  (m_up_wack),
    .m_up_rreq  (m_up_rreq),
    .m_up_raddr (m_up_raddr),
    .m_up_rdata (m_up_rdata),
    .m_up_rack  (m_up_rack),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  int checks = 0;
  int errors = 0;

  // Slave state and transaction logs.
  int          wack_dly = 1;
  bit          stall = 1'b0;
  bit          sr_stuck = 1'b0;
  int          sr_busy_left = 0;
  bit          wpend = 1'b0;
  bit          rpend = 1'b0;
  int          wcnt = 0;
  logic [AW-1:0] waddr_log [$];
  logic [31:0]   wdata_log [$];
  int          n_reads = 0;
  int          done_cnt = 0;

  typedef struct {
    logic [1:0]  cs;
    logic [5:0]  len;
    logic [31:0] data;
    int          busy_reads;
    logic [31:0] exp_cr;
    int          exp_reads;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Register-bus slave, sampled 1 time unit after each rising edge.
  initial begin
    m_up_wack  = 1'b0;
    m_up_rack  = 1'b0;
    m_up_rdata = 32'h0;
    forever begin
      @(posedge up_clk);
      #1;
      m_up_wack = 1'b0;
      m_up_rack = 1'b0;
      if (done) done_cnt++;
      if (!up_rstn) begin
        wpend = 1'b0;
        rpend = 1'b0;
      end else begin
        if (m_up_wreq) begin
          checks++;
          if (wpend || rpend) begin
            errors++;
            $display("FAIL bus_overlap: wreq addr=%0d while access outstanding", m_up_waddr);
          end
          waddr_log.push_back(m_up_waddr);
          wdata_log.push_back(m_up_wdata);
          $display("write addr=%0d data=0x%08h", m_up_waddr, m_up_wdata);
          wpend = 1'b1;
          wcnt  = wack_dly;
        end
        if (m_up_rreq) begin
          checks++;
          if (wpend || rpend || m_up_raddr != 12'd1) begin
            errors++;
            $display("FAIL bus_read: raddr=%0d (want 1) or access outstanding", m_up_raddr);
          end
          n_reads++;
          rpend = 1'b1;
        end
        if (wpend && !stall) begin
          if (wcnt <= 0) begin
            m_up_wack = 1'b1;
            wpend     = 1'b0;
          end else begin
            wcnt--;
          end
        end
        if (rpend) begin
          m_up_rack  = 1'b1;
          m_up_rdata = (sr_stuck || sr_busy_left > 0) ? 32'h1 : 32'h0;
          if (sr_busy_left > 0) sr_busy_left--;
          rpend = 1'b0;
          $display("read SR -> 0x%08h", m_up_rdata);
        end
      end
    end
  end

  task automatic clear_logs();
    waddr_log.delete();
    wdata_log.delete();
    n_reads = 0;
  endtask

  // Assert reset for one edge, check reset values right after it, release.
  task automatic do_reset(input string tag);
    @(negedge up_clk);
    up_rstn   = 1'b0;
    cmd_valid = 1'b0;
    @(posedge up_clk);
    #1;
    chk({tag, "_wreq"},  32'(m_up_wreq), 32'h0);
    chk({tag, "_waddr"}, 32'(m_up_waddr), 32'h0);
    chk({tag, "_wdata"}, m_up_wdata, 32'h0);
    chk({tag, "_rreq"},  32'(m_up_rreq), 32'h0);
    chk({tag, "_raddr"}, 32'(m_up_raddr), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_done"},  32'(done), 32'h0);
    chk({tag, "_err"},   32'(err), 32'h0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'h0);
    @(negedge up_clk);
    clear_logs();
    done_cnt = 0;
    up_rstn  = 1'b1;
    $display("reset released (%s)", tag);
  endtask

  task automatic push(input logic [1:0] cs, input logic [5:0] len, input logic [31:0] data);
    int n;
    @(negedge up_clk);
    cmd_cs    = cs;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge up_clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
    end else begin
      @(posedge up_clk);
      #1;
      cmd_valid = 1'b0;
      $display("push cs=%b len=%0d data=0x%08h", cs, len, data);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n;
    n = 0;
    @(negedge up_clk);
    while ((busy || wpend || rpend) && n < max_cycles) begin
      @(negedge up_clk);
      n++;
    end
    chk({name, "_idle_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    up_rstn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_cs    = '0;
    cmd_len   = '0;
    cmd_data  = '0;

    vecs[0] = '{cs: 2'b01, len: 6'd7,  data: 32'h0000_00A5, busy_reads: 3, exp_cr: 32'h0001_070D, exp_reads: 4};
    vecs[1] = '{cs: 2'b10, len: 6'd31, data: 32'hDEAD_BEEF, busy_reads: 0, exp_cr: 32'h0002_1F0D, exp_reads: 1};
    vecs[2] = '{cs: 2'b11, len: 6'd0,  data: 32'h0000_0001, busy_reads: 1, exp_cr: 32'h0003_000D, exp_reads: 2};
    vecs[3] = '{cs: 2'b00, len: 6'd63, data: 32'hFFFF_FFFF, busy_reads: 2, exp_cr: 32'h0000_3F0D, exp_reads: 3};

    // Reset and prescaler programming.
    do_reset("rst0");
    n = 0;
    while ((waddr_log.size() == 0 || wpend) && n < 50) begin
      @(negedge up_clk);
      n++;
    end
    repeat (3) @(negedge up_clk);
    chk("init_wcount", 32'(waddr_log.size()), 32'd1);
    if (waddr_log.size() > 0) begin
      chk("init_psc_addr", 32'(waddr_log[0]), 32'd3);
      chk("init_psc_data", wdata_log[0], 32'd4);
    end
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_ready", 32'(cmd_ready), 32'h1);

    // Table-driven single transfers.
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      sr_busy_left = vecs[i].busy_reads;
      d0 = done_cnt;
      push(vecs[i].cs, vecs[i].len, vecs[i].data);
      wait_idle(300, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_wcount", i), 32'(waddr_log.size()), 32'd3);
      if (waddr_log.size() == 3) begin
        chk($sformatf("vec%0d_dis_addr", i), 32'(waddr_log[0]), 32'd0);
        chk($sformatf("vec%0d_dis_data", i), wdata_log[0], 32'h0);
        chk($sformatf("vec%0d_odr_addr", i), 32'(waddr_log[1]), 32'd2);
        chk($sformatf("vec%0d_odr_data", i), wdata_log[1], vecs[i].data);
        chk($sformatf("vec%0d_cr_addr", i), 32'(waddr_log[2]), 32'd0);
        chk($sformatf("vec%0d_cr_data", i), wdata_log[2], vecs[i].exp_cr);
      end
      chk($sformatf("vec%0d_reads", i), 32'(n_reads), 32'(vecs[i].exp_reads));
      chk($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'h0);
      $display("vector %0d complete", i);
    end

    // Poll timeout: SR stuck busy.
    clear_logs();
    sr_stuck = 1'b1;
    d0 = done_cnt;
    push(2'b01, 6'd3, 32'h0000_000F);
    wait_idle(300, "tmo");
    chk("tmo_reads", 32'(n_reads), 32'd4);
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    sr_stuck = 1'b0;
    d0 = done_cnt;
    push(2'b10, 6'd5, 32'h0000_002A);
    wait_idle(300, "tmo_next");
    chk("tmo_next_done", 32'(done_cnt - d0), 32'd1);
    if (wdata_log.size() >= 5) chk("tmo_next_odr", wdata_log[4], 32'h0000_002A);
    chk("tmo_err_sticky", 32'(err), 32'h1);

    // FIFO fill while the PSC write is stalled.
    stall = 1'b1;
    do_reset("rst1");
    for (int i = 0; i < 4; i++) push(2'(i), 6'(i), 32'h100 + 32'(i));
    @(negedge up_clk);
    chk("full_ready_low", 32'(cmd_ready), 32'h0);
    repeat (3) @(negedge up_clk);
    chk("full_ready_held", 32'(cmd_ready), 32'h0);
    stall = 1'b0;
    push(2'b01, 6'd4, 32'h104);
    wait_idle(1000, "fifo");
    chk("fifo_wcount", 32'(waddr_log.size()), 32'd16);
    if (waddr_log.size() == 16) begin
      chk("fifo_psc_addr", 32'(waddr_log[0]), 32'd3);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("fifo_odr_addr%0d", i), 32'(waddr_log[2 + 3 * i]), 32'd2);
        chk($sformatf("fifo_odr_data%0d", i), wdata_log[2 + 3 * i], 32'h100 + 32'(i));
      end
    end
    chk("fifo_done", 32'(done_cnt), 32'd5);

    // Reset during LOAD with a second command queued.
    wack_dly = 4;
    push(2'b01, 6'd7, 32'h0000_0055);
    push(2'b10, 6'd7, 32'h0000_0066);
    n = 0;
    while (!(m_up_wreq && m_up_waddr == 12'd2) && n < 200) begin
      @(negedge up_clk);
      n++;
    end
    chk("load_reached", 32'(m_up_wreq && m_up_waddr == 12'd2), 32'h1);
    wack_dly = 1;
    do_reset("rst2");
    repeat (40) @(negedge up_clk);
    chk("abort_wcount", 32'(waddr_log.size()), 32'd1);
    if (waddr_log.size() >= 1) begin
      chk("abort_psc_addr", 32'(waddr_log[0]), 32'd3);
      chk("abort_psc_data", wdata_log[0], 32'd4);
    end
    chk("abort_reads", 32'(n_reads), 32'd0);
    chk("abort_done", 32'(done_cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
